image_frame_feeder: RTL and testbench

IMAGE_FRAME_FEEDER -- requirements
Module: image_frame_feeder

---
 rtl/image_frame_feeder.sv | 142 ++++++++++++++
 tb/tb_image_frame_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_feeder.sv
// Image frame feeder: buffers one host frame and replays it to the CNN without gaps.
// It then waits, with a timeout, for the class result.
module image_frame_feeder #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       cnn_in_valid,
  output logic [7:0] cnn_in_data,
  input  logic [3:0] cnn_class_out,
  input  logic       cnn_class_valid,
  output logic [3:0] res_class,
  output logic       res_valid,
  output logic       res_err,
  output logic       busy
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int PW = $clog2(N + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [TW-1:0] r_count;
  logic          r_sReady;
  logic          r_cnnValid;
  logic [7:0]    r_cnnData;
  logic [3:0]    r_resClass;
  logic          r_resValid;
  logic          r_resErr;
  logic          r_busy;
  logic [7:0]    r_buf [N];

  logic w_accept;
  logic w_lastBeat;
  logic w_streamDone;
  logic w_timeout;

  assign w_accept     = s_valid && r_sReady && (r_state == ST_LOAD);
  assign w_lastBeat   = (r_wrPtr == PW'(N - 1));
  assign w_streamDone = (r_rdPtr == PW'(N));
  assign w_timeout    = (r_count == TW'(TIMEOUT - 1));

  // Pixel store has no reset; a frame interrupted by reset is simply overwritten.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wrPtr[AW-1:0]] <= s_data;
    end
  end

  // rd_ptr runs one step past N-1 so the WAIT entry cycle already shows cnn_in_valid low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_LOAD;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_sReady   <= 1'b0;
      r_cnnValid <= 1'b0;
      r_cnnData  <= 8'd0;
      r_resClass <= 4'd0;
      r_resValid <= 1'b0;
      r_resErr   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_resValid <= 1'b0;
      r_resErr   <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_sReady   <= 1'b1;
          r_busy     <= 1'b0;
          r_cnnValid <= 1'b0;
          if (w_accept) begin
            if (w_lastBeat) begin
              r_wrPtr  <= '0;
              r_rdPtr  <= '0;
              r_sReady <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= ST_STREAM;
            end else if (s_last) begin
              r_wrPtr  <= '0;
              r_resErr <= 1'b1;
            end else begin
              r_wrPtr <= r_wrPtr + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (w_streamDone) begin
            r_cnnValid <= 1'b0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_state    <= ST_WAIT;
          end else begin
            r_cnnValid <= 1'b1;
            r_cnnData  <= r_buf[r_rdPtr[AW-1:0]];
            r_rdPtr    <= r_rdPtr + 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnn_class_valid) begin
            r_resClass <= cnn_class_out;
            r_resValid <= 1'b1;
            r_sReady   <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_LOAD;
          end else if (w_timeout) begin
            r_resErr <= 1'b1;
            r_sReady <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_LOAD;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign s_ready      = r_sReady;
  assign cnn_in_valid = r_cnnValid;
  assign cnn_in_data  = r_cnnData;
  assign res_class    = r_resClass;
  assign res_valid    = r_resValid;
  assign res_err      = r_resErr;
  assign busy         = r_busy;

endmodule

// File: tb/tb_image_frame_feeder.sv
// Bench for image_frame_feeder: directed frame scenarios with random data and throttling,
// checked against a queue model of the accepted pixels and cycle arithmetic.
module tb_image_frame_feeder;
  localparam int N   = 28 * 28;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       cnn_in_valid;
  logic [7:0] cnn_in_data;
  logic [3:0] cnn_class_out;
  logic       cnn_class_valid;
  logic [3:0] res_class;
  logic       res_valid;
  logic       res_err;
  logic       busy;

  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;
  logic [3:0] lastClass = 4'd0;
  logic [7:0] expQ[$];
  logic [7:0] captData[$];
  int         captCyc[$];

  image_frame_feeder #(.IMG_W(28), .IMG_H(28), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .cnn_in_valid(cnn_in_valid), .cnn_in_data(cnn_in_data),
    .cnn_class_out(cnn_class_out), .cnn_class_valid(cnn_class_valid),
    .res_class(res_class), .res_valid(res_valid), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are captured away from the rising edge, tagged with the cycle they belong to.
  always @(negedge clk) begin
    if (cnn_in_valid === 1'b1) begin
      captData.push_back(cnn_in_data);
      captCyc.push_back(cyc);
    end
    if (rst_n === 1'b1 && (res_valid === 1'b1 || res_err === 1'b1))
      checkOutput("res_exclusive", {31'd0, res_valid & res_err}, 0);
  end

  task automatic stepTo(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic applyStimulus(input int nBeats, input int lastAt, input int validPct,
                               input bit rampData, input bit holdValid, output int tLast);
    int acc = 0;
    int guard = 0;
    tLast = cyc;
    expQ.delete();
    captData.delete();
    captCyc.delete();
    while (acc < nBeats && guard < 20000) begin
      bit v;
      v       = ($urandom_range(99) < validPct);
      s_valid = v;
      s_data  = rampData ? 8'(acc) : 8'($urandom);
      s_last  = (acc + 1 == lastAt);
      if (v && s_ready === 1'b1) begin
        expQ.push_back(s_data);
        acc++;
        tLast = cyc;
      end
      @(negedge clk);
      guard++;
    end
    s_valid = holdValid;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
    checkOutput("load_beats", acc, nBeats);
  endtask

  task automatic checkStream(input int tLast, input string tag, output int w);
    int errs = 0;
    w = tLast + N + 2;
    stepTo(tLast + 1);
    checkOutput({tag, "_busy_on"}, {31'd0, busy}, 1);
    checkOutput({tag, "_ready_off"}, {31'd0, s_ready}, 0);
    stepTo(w);
    for (int i = 0; i < captData.size() && i < expQ.size(); i++)
      if (captData[i] !== expQ[i]) errs++;
    checkOutput({tag, "_count"}, captData.size(), N);
    checkOutput({tag, "_first_cycle"}, (captCyc.size() > 0) ? captCyc[0] : -1, tLast + 2);
    checkOutput({tag, "_last_cycle"}, (captCyc.size() > 0) ? captCyc[$] : -1, tLast + N + 1);
    checkOutput({tag, "_data_errs"}, errs, 0);
    checkOutput({tag, "_wait_valid_low"}, {31'd0, cnn_in_valid}, 0);
    checkOutput({tag, "_wait_busy"}, {31'd0, busy}, 1);
    checkOutput({tag, "_wait_ready"}, {31'd0, s_ready}, 0);
  endtask

  task automatic respond(input int w, input int d, input logic [3:0] cls, input string tag);
    stepTo(w + d);
    s_valid         = 1'b0;
    cnn_class_valid = 1'b1;
    cnn_class_out   = cls;
    @(negedge clk);
    checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 1);
    checkOutput({tag, "_res_class"}, {28'd0, res_class}, {28'd0, cls});
    checkOutput({tag, "_res_err"}, {31'd0, res_err}, 0);
    checkOutput({tag, "_ready_back"}, {31'd0, s_ready}, 1);
    checkOutput({tag, "_busy_off"}, {31'd0, busy}, 0);
    cnn_class_valid = 1'b0;
    cnn_class_out   = 4'($urandom);
    @(negedge clk);
    checkOutput({tag, "_res_pulse"}, {31'd0, res_valid}, 0);
    lastClass = cls;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int t;
    int w;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;
    cnn_class_valid = 1'b0; cnn_class_out = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_s_ready", {31'd0, s_ready}, 0);
    checkOutput("rst_cnn_valid", {31'd0, cnn_in_valid}, 0);
    checkOutput("rst_cnn_data", {24'd0, cnn_in_data}, 0);
    checkOutput("rst_res_class", {28'd0, res_class}, 0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 0);
    checkOutput("rst_res_err", {31'd0, res_err}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_s_ready", {31'd0, s_ready}, 1);

    $display("[TB] nominal ramp frame");
    applyStimulus(N, N, 100, 1'b1, 1'b0, t);
    checkStream(t, "nom", w);
    respond(w, $urandom_range(0, 20), 4'd7, "nom");

    $display("[TB] throttled frame");
    applyStimulus(N, N, 50, 1'b0, 1'b0, t);
    checkStream(t, "thr", w);
    respond(w, $urandom_range(0, 20), 4'($urandom), "thr");

    $display("[TB] short frame then full frame");
    applyStimulus(100, 100, 100, 1'b0, 1'b0, t);
    checkOutput("short_err", {31'd0, res_err}, 1);
    checkOutput("short_ready", {31'd0, s_ready}, 1);
    checkOutput("short_busy", {31'd0, busy}, 0);
    @(negedge clk);
    checkOutput("short_err_pulse", {31'd0, res_err}, 0);
    repeat (5) @(negedge clk);
    checkOutput("short_no_stream", captData.size(), 0);
    applyStimulus(N, N, 100, 1'b0, 1'b0, t);
    checkStream(t, "after_short", w);
    respond(w, $urandom_range(0, 20), 4'd12, "after_short");

    $display("[TB] timeout without class");
    applyStimulus(N, N, 100, 1'b0, 1'b0, t);
    checkStream(t, "tmo", w);
    stepTo(w + TMO - 1);
    checkOutput("tmo_early", {31'd0, res_err}, 0);
    @(negedge clk);
    checkOutput("tmo_err", {31'd0, res_err}, 1);
    checkOutput("tmo_no_valid", {31'd0, res_valid}, 0);
    checkOutput("tmo_class_kept", {28'd0, res_class}, {28'd0, lastClass});
    checkOutput("tmo_ready", {31'd0, s_ready}, 1);
    checkOutput("tmo_busy", {31'd0, busy}, 0);
    @(negedge clk);
    checkOutput("tmo_err_pulse", {31'd0, res_err}, 0);

    $display("[TB] class at terminal count");
    applyStimulus(N, N, 100, 1'b0, 1'b0, t);
    checkStream(t, "term", w);
    respond(w, TMO - 1, 4'd3, "term");

    $display("[TB] reset mid-stream");
    applyStimulus(N, N, 100, 1'b0, 1'b0, t);
    stepTo(t + 2 + 300);
    rst_n = 1'b0;
    cnn_class_valid = 1'b1;
    cnn_class_out = 4'd9;
    @(negedge clk);
    checkOutput("mrst_valid", {31'd0, cnn_in_valid}, 0);
    checkOutput("mrst_busy", {31'd0, busy}, 0);
    checkOutput("mrst_ready", {31'd0, s_ready}, 0);
    checkOutput("mrst_pixels", captData.size(), 301);
    rst_n = 1'b1;
    lastClass = 4'd0;
    @(negedge clk);
    checkOutput("mrst_ready_rel", {31'd0, s_ready}, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stale_no_valid", {31'd0, res_valid}, 0);
      checkOutput("stale_class", {28'd0, res_class}, 0);
      @(negedge clk);
    end
    cnn_class_valid = 1'b0;

    $display("[TB] back-pressure during stream and wait");
    applyStimulus(N, N, 100, 1'b0, 1'b1, t);
    checkStream(t, "bp", w);
    respond(w, $urandom_range(0, 20), 4'd5, "bp");

    $display("[TB] final throttled frame");
    applyStimulus(N, N, 50, 1'b0, 1'b0, t);
    checkStream(t, "fin", w);
    respond(w, $urandom_range(0, 20), 4'($urandom), "fin");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
